// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit-time divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver plus the raw serial line.
interface uart_rx_if;
  import uart_pkg::*;

  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  modport master (
    output RX,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err,
    input  ovr_err
  );

  modport slave (
    input  RX,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err,
    output ovr_err
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops preset to 1 so an idle line reads high.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a down-counting baud timer, sticky framing/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(BAUD_DIV) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_q, data_nxt;
  logic             rdy_q, rdy_nxt;
  logic             frm_q, frm_nxt;
  logic             ovr_q, ovr_nxt;
  logic             armed, armed_nxt;
  logic             rx_s;
  logic             tick;
  logic             done;
  logic             stop_low;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.RX),
    .q   (rx_s)
  );

  assign tick = (cnt == ONE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_nxt    = data_q;
    // A break (stop bit low) disarms the start detector until the line has been high again.
    armed_nxt   = armed | rx_s;
    done        = 1'b0;
    stop_low    = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (armed && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = HALF;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            cnt_nxt     = FULL;
          end
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt   = {rx_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          cnt_nxt     = FULL;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      STOP: begin
        if (tick) begin
          data_nxt  = shift;
          done      = 1'b1;
          stop_low  = !rx_s;
          if (!rx_s) armed_nxt = 1'b0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Setting a flag always wins over a coincident clr_rdy.
    rdy_nxt = done | (rdy_q & ~bus.clr_rdy);
    ovr_nxt = (done & rdy_q & ~bus.clr_rdy) | (ovr_q & ~bus.clr_rdy);
    frm_nxt = stop_low | (frm_q & ~bus.clr_rdy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
      armed   <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      rdy_q   <= rdy_nxt;
      frm_q   <= frm_nxt;
      ovr_q   <= ovr_nxt;
      armed   <= armed_nxt;
    end
  end

  assign bus.rx_data = data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_q;
  assign bus.ovr_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIV=16: directed corner sequences, a vector table and random frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  uart_rx_if bus ();

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic       exp_frm;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bus.RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (BD) @(negedge clk);
    end
    bus.RX = stop;
    repeat (BD) @(negedge clk);
    bus.RX = 1'b1;
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic r, input logic [7:0] d,
                         input logic f, input logic o);
    chk({tag, ".rdy"},     bus.rdy,     r);
    chk({tag, ".rx_data"}, bus.rx_data, d);
    chk({tag, ".frm_err"}, bus.frm_err, f);
    chk({tag, ".ovr_err"}, bus.ovr_err, o);
  endtask

  initial begin
    logic       m_rdy, m_frm, m_ovr;
    logic [7:0] m_data;

    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0xA5: rdy appears exactly 153 clk after the synchronized edge (2 more from the line edge)
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (BD*9 + BD/2 + 2) @(negedge clk);
        chk("lat.rdy_early", bus.rdy, 1'b0);
        @(negedge clk);
        chk("lat.rdy", bus.rdy, 1'b1);
        chk("lat.rx_data", bus.rx_data, 8'hA5);
        chk("lat.frm_err", bus.frm_err, 1'b0);
      end
    join
    repeat (4) @(negedge clk);

    // clr_rdy coincides with a completing frame whose stop bit is low: both sets win
    fork
      send_frame(8'hC3, 1'b0);
      begin
        repeat (BD*9 + BD/2 + 2) @(negedge clk);
        pulse_clr();
      end
    join
    repeat (4) @(negedge clk);
    chk_all("coinc", 1'b1, 8'hC3, 1'b1, 1'b0);

    // 5-clk low glitch is rejected by the START check
    pulse_clr();
    bus.RX = 1'b0;
    repeat (5) @(negedge clk);
    bus.RX = 1'b1;
    repeat (40) @(negedge clk);
    chk_all("glitch", 1'b0, 8'hC3, 1'b0, 1'b0);

    // Break: stop bit low, line held low 64 clk; no second capture
    send_frame(8'h3C, 1'b0);
    bus.RX = 1'b0;
    repeat (64) @(negedge clk);
    bus.RX = 1'b1;
    repeat (40) @(negedge clk);
    chk_all("break", 1'b1, 8'h3C, 1'b1, 1'b0);

    // Back-to-back frames without acknowledge, then one clr_rdy
    pulse_clr();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("b2b", 1'b1, 8'h22, 1'b0, 1'b1);
    pulse_clr();
    chk("b2b_clr.rdy", bus.rdy, 1'b0);
    chk("b2b_clr.ovr_err", bus.ovr_err, 1'b0);

    // Reset during data bit 4 of 0xFF, then a clean 0x5A
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (BD*5 + BD/2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("rstmid.rdy", bus.rdy, 1'b0);
    chk("rstmid.rx_data", bus.rx_data, 8'h00);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    chk_all("after_rst", 1'b1, 8'h5A, 1'b0, 1'b0);

    // Table: {data, stop, clr before, expected rdy, rx_data, frm_err, ovr_err}
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    tbl[4] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0};
    tbl[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[6] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    tbl[7] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) pulse_clr();
      send_frame(tbl[i].data, tbl[i].stop);
      repeat (4) @(negedge clk);
      chk_all($sformatf("tbl%0d", i), tbl[i].exp_rdy, tbl[i].exp_data,
              tbl[i].exp_frm, tbl[i].exp_ovr);
    end

    // Random frames against a flag/byte model
    pulse_clr();
    m_rdy  = 1'b0;
    m_frm  = 1'b0;
    m_ovr  = 1'b0;
    m_data = 8'h5A;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      logic       stop;
      logic       clr;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      clr  = 1'($urandom_range(0, 1));
      if (clr) begin
        pulse_clr();
        m_rdy = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
      end
      send_frame(b, stop);
      m_ovr  = m_ovr | m_rdy;
      m_frm  = m_frm | ~stop;
      m_rdy  = 1'b1;
      m_data = b;
      repeat (2) @(negedge clk);
      chk_all($sformatf("rnd%0d", n), m_rdy, m_data, m_frm, m_ovr);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, is the number of clk cycles per bit time and SHALL be at least 4 and even.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 RX  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 clr_rdy  input  1  single-cycle pulse from the consumer acknowledging rx_data.
REQ-006 rx_data  output  8  last received byte; held stable while rdy=1.
REQ-007 rdy  output  1  a new byte is valid in rx_data.
REQ-008 frm_err  output  1  sticky flag: the last frame's stop bit sampled low.
REQ-009 ovr_err  output  1  sticky flag: a byte completed while rdy was already 1.

Function
REQ-010 RX SHALL pass through a two-flop synchronizer before any use; both flops preset to 1; added latency is 2 clk.
REQ-011 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-012 IDLE: on synchronized RX=0, go to START and load the baud counter with BAUD_DIV/2.
REQ-013 START: when the counter expires, sample RX.
- RX=0: go to DATA, bit_cnt=0, and reload the counter with BAUD_DIV.
- RX=1: glitch; return to IDLE with no flag change.
REQ-014 DATA: on each counter expiry, right-shift the sampled bit into the MSB of the 8-bit shift register and increment bit_cnt; after the 8th sample, go to STOP and reload the counter.
REQ-015 STOP: on counter expiry, sample the stop bit and copy the shift register into rx_data.
- RX=1: frm_err unchanged.
- RX=0: set frm_err.
- In both cases, return to IDLE the next cycle.
REQ-016 Stop bit 0 (break): IDLE SHALL NOT re-arm until synchronized RX has been seen high at least once.
REQ-017 rdy SHALL rise in the cycle after the stop sample, regardless of stop value; latency from the synchronized falling edge is 9.5*BAUD_DIV clk, +1 cycle.
REQ-018 rdy clears on clr_rdy; if the set and the clear coincide, set SHALL win.
REQ-019 Byte completes while rdy=1 and clr_rdy is absent: set ovr_err and overwrite rx_data with the new byte.
REQ-020 frm_err and ovr_err clear only on clr_rdy or reset; a simultaneous set SHALL win.
REQ-021 Baud counter SHALL be $clog2(BAUD_DIV)+1 bits, count down, and expire on reaching 1; it SHALL NOT wrap while in IDLE.
REQ-022 rx_data SHALL change only on the stop-sample update.

Reset
REQ-023 With rst=1 at a clk edge:
- state=IDLE, rdy=0, frm_err=0, ovr_err=0, rx_data=8'h00;
- shift register=8'h00, bit_cnt=0, counter=0;
- synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no rdy pulse; reception resumes on the next falling edge seen after rst deasserts.

Structure
REQ-025 Package uart_pkg SHALL hold the rx_state_t enum {IDLE, START, DATA, STOP} and the DEFAULT_BAUD_DIV=2604 constant, shared with the transmitter.
REQ-026 The synchronizer SHALL be a separate sub-module, sync2 (1-bit, preset-to-1 on rst); everything else is in uart_rx.

Verification (bench uses BAUD_DIV=16)
REQ-027 Frame 0xA5 with stop=1 -> rdy=1 and rx_data=8'hA5 at 153 clk after the synchronized edge; frm_err=0.
REQ-028 RX low pulse of 5 clk in IDLE -> START rejects it; rdy, frm_err and rx_data unchanged; FSM back in IDLE.
REQ-029 Frame 0x3C with stop=0, then RX held low for 64 clk, then high -> rdy=1, rx_data=8'h3C, frm_err=1; no second frame captured during the low hold.
REQ-030 Frames 0x11 then 0x22 back-to-back with no clr_rdy -> rx_data=8'h22, ovr_err=1; one clr_rdy pulse then clears rdy and ovr_err.
REQ-031 clr_rdy asserted in the same cycle rdy sets -> rdy=1 afterwards.
REQ-032 rst pulsed at bit 4 of frame 0xFF, then frame 0x5A -> no rdy for 0xFF; rx_data=8'h5A, rdy=1, both error flags 0.
